// File: rtl/spi_byte_queue.sv
// Byte queue between a host and an SPI master: a TX FIFO feeds the master one byte at a time
// and each received byte goes into an RX FIFO. A missing spi_done times the exchange out.
//
// state   | meaning
// S_IDLE  | waiting for a byte in the TX FIFO
// S_LOAD  | spi_send pulse, TX head popped
// S_WAIT  | exchange in flight, timeout counter running
// S_STORE | captured byte pushed into the RX FIFO
module spi_byte_queue #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tx_full,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rx_empty,
  output logic [4:0] tx_count,
  output logic [4:0] rx_count,
  output logic [7:0] spi_data,
  output logic       spi_send,
  input  logic       spi_done,
  input  logic [7:0] spi_rx_data,
  output logic       busy,
  output logic       rx_overflow,
  output logic       timeout_err
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C  = 5'(DEPTH);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STORE} state_t;

  state_t state, state_nxt;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [4:0]    tx_cnt;
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [4:0]    rx_cnt;

  logic [9:0] tmo_cnt;
  logic [7:0] rx_capture;
  logic       tx_pop_req, rx_push_req, tmo_hit;
  logic       tx_push, tx_pop, rx_push, rx_pop;

  assign tx_full  = (tx_cnt == DEPTH_C);
  assign tx_count = tx_cnt;
  assign rx_empty = (rx_cnt == 5'd0);
  assign rx_count = rx_cnt;
  assign rd_data  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

  // Full FIFO refuses pushes and empty FIFO refuses pops, which also resolves the
  // simultaneous push/pop corner cases.
  assign tx_push = wr_en && !tx_full;
  assign tx_pop  = tx_pop_req && (tx_cnt != 5'd0);
  assign rx_push = rx_push_req && (rx_cnt != DEPTH_C);
  assign rx_pop  = rd_en && !rx_empty;

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wr_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_capture;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= 5'd0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= 5'd0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 5'd1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 5'd1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 5'd1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tx_cnt != 5'd0) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (spi_done)     state_nxt = S_STORE;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_STORE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    spi_send    = (state == S_LOAD);
    busy        = (state != S_IDLE);
    tx_pop_req  = (state == S_LOAD);
    rx_push_req = (state == S_STORE);
    tmo_hit     = (state == S_WAIT) && !spi_done && (tmo_cnt == TMO_LAST);
  end

  // spi_data is loaded on the way into LOAD so it is already valid alongside spi_send.
  always_ff @(posedge clock) begin
    if (reset) begin
      spi_data    <= 8'h00;
      rx_capture  <= 8'h00;
      tmo_cnt     <= 10'd0;
      rx_overflow <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_IDLE && tx_cnt != 5'd0) spi_data <= tx_mem[tx_rd_ptr];
      if (state == S_LOAD)      tmo_cnt <= 10'd0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 10'd1;
      if (state == S_WAIT && spi_done) rx_capture <= spi_rx_data;
      if (tmo_hit) timeout_err <= 1'b1;
      if (rx_push_req && (rx_cnt == DEPTH_C)) rx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_byte_queue.sv
// Directed bench for spi_byte_queue: latency, TX/RX FIFO limits, overflow, timeout,
// simultaneous RX push/pop and mid-transaction reset.
module tb_spi_byte_queue;

  logic       clock = 1'b0;
  logic       reset, wr_en, rd_en, spi_done;
  logic [7:0] wr_data, spi_rx_data;
  logic       tx_full, rx_empty, spi_send, busy, rx_overflow, timeout_err;
  logic [7:0] rd_data, spi_data;
  logic [4:0] tx_count, rx_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_num  = 0;

  spi_byte_queue #(.DEPTH(8), .TIMEOUT(1023)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .tx_count(tx_count),
    .rx_count(rx_count), .spi_data(spi_data), .spi_send(spi_send), .spi_done(spi_done),
    .spi_rx_data(spi_rx_data), .busy(busy), .rx_overflow(rx_overflow),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc_num <= cyc_num + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_send(input string tag);
    int n = 0;
    while (!spi_send && n < 50) begin cyc(); n++; end
    check({tag, "_send_seen"}, spi_send, 1);
  endtask

  // Called in a WAIT cycle; returns at the IDLE cycle after STORE.
  task automatic finish_xfer(input logic [7:0] rx);
    spi_done = 1'b1; spi_rx_data = rx;
    cyc();
    spi_done = 1'b0;
    cyc();
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, rd_data, exp);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_spi_data"}, spi_data, 0);
    check({tag, "_spi_send"}, spi_send, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rx_ovf"}, rx_overflow, 0);
    check({tag, "_tmo_err"}, timeout_err, 0);
    check({tag, "_tx_full"}, tx_full, 0);
    check({tag, "_rx_empty"}, rx_empty, 1);
    check({tag, "_tx_count"}, tx_count, 0);
    check({tag, "_rx_count"}, rx_count, 0);
    check({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t_prev, t_now;
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; spi_done = 1'b0;
    wr_data = 8'h00; spi_rx_data = 8'h00;
    cyc(); cyc();
    check_reset_outputs("por");
    reset = 1'b0;
    cyc();

    // single exchange: latency of spi_send and of rd_data
    push(8'hA5);
    check("t1_c1_send", spi_send, 0);
    check("t1_c1_txcnt", tx_count, 1);
    cyc();
    check("t1_c2_send", spi_send, 1);
    check("t1_c2_data", spi_data, 8'hA5);
    check("t1_c2_busy", busy, 1);
    cyc();
    check("t1_send_1cyc", spi_send, 0);
    check("t1_data_held", spi_data, 8'hA5);
    check("t1_txcnt0", tx_count, 0);
    spi_done = 1'b1; spi_rx_data = 8'h3C;
    cyc();
    spi_done = 1'b0;
    check("t1_store_empty", rx_empty, 1);
    cyc();
    check("t1_rd_data", rd_data, 8'h3C);
    check("t1_rxcnt", rx_count, 1);
    check("t1_idle", busy, 0);
    pop_check("t1_pop", 8'h3C);
    check("t1_rx_empty", rx_empty, 1);

    // TX full while the FSM is in WAIT, in-order transmit, RX overflow
    do_reset();
    push(8'h11);
    wait_send("t2_first");
    cyc();
    for (int i = 0; i < 9; i++) push(8'h20 + 8'(i));
    check("t2_txcnt_full", tx_count, 8);
    check("t2_tx_full", tx_full, 1);
    finish_xfer(8'hEE);
    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      wait_send("t2_loop");
      t_now = cyc_num;
      if (i > 0) check("t2_gap", ((t_now - t_prev) >= 2) ? 1 : 0, 1);
      t_prev = t_now;
      check("t2_order", spi_data, 8'h20 + 8'(i));
      cyc();
      finish_xfer((8'h20 + 8'(i)) ^ 8'hFF);
    end
    repeat (5) cyc();
    check("t2_no_9th", busy, 0);
    check("t2_txcnt0", tx_count, 0);
    check("t2_rxcnt8", rx_count, 8);
    check("t2_rx_ovf", rx_overflow, 1);
    pop_check("t2_rd0", 8'hEE);
    for (int i = 0; i < 7; i++) pop_check("t2_rd", (8'h20 + 8'(i)) ^ 8'hFF);
    check("t2_rx_empty", rx_empty, 1);
    check("t2_ovf_sticky", rx_overflow, 1);

    // timeout with spi_done withheld
    do_reset();
    push(8'h5A);
    wait_send("t3");
    cyc();
    n = 0;
    while (!timeout_err && n < 1100) begin cyc(); n++; end
    check("t3_tmo_cycles", n, 1023);
    check("t3_idle", busy, 0);
    check("t3_no_rx", rx_empty, 1);
    spi_done = 1'b1; spi_rx_data = 8'h55;
    cyc();
    spi_done = 1'b0;
    cyc(); cyc();
    check("t3_done_idle_ignored", rx_count, 0);
    check("t3_tmo_sticky", timeout_err, 1);

    // rd_en coinciding with the STORE push at rx_count=3
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      push(8'(i));
      wait_send("t4_fill");
      check("t4_fill_data", spi_data, 8'(i));
      cyc();
      finish_xfer(8'h80 + 8'(i));
    end
    check("t4_rxcnt3", rx_count, 3);
    push(8'h04);
    wait_send("t4_last");
    cyc();
    spi_done = 1'b1; spi_rx_data = 8'h84;
    cyc();
    spi_done = 1'b0;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check("t4_rxcnt_same", rx_count, 3);
    pop_check("t4_rd1", 8'h82);
    pop_check("t4_rd2", 8'h83);
    pop_check("t4_rd3", 8'h84);
    check("t4_empty", rx_empty, 1);

    // reset during WAIT, then a late spi_done
    do_reset();
    push(8'h77);
    wait_send("t5");
    cyc();
    check("t5_in_wait", busy, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    spi_done = 1'b1; spi_rx_data = 8'h99;
    cyc();
    spi_done = 1'b0;
    cyc(); cyc();
    check_reset_outputs("t5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
